addsub_seq_ctrl: RTL

Sequencing controller for the team's shared 4-bit add/subtract datapath (ripple adder with S-controlled complement, carry/borrow and overflow outputs). It accepts a command with start/busy/done handshake and drives the external datapath operands and mode. It captures total/carry/overflow into result registers that feed the 7-segment decoder. Adds accumulate mode and multi-cycle multiply by repeated addition on the same datapath.

---
 rtl/addsub_seq_ctrl_if.sv | 32 +++
 rtl/addsub_seq_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/addsub_seq_ctrl_if.sv
// Command handshake and external add/sub datapath signals for addsub_seq_ctrl.
// The master side is the command issuer together with the datapath; the slave side is the controller.
interface addsub_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             use_acc;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ov;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic             dp_s;
    logic [WIDTH-1:0] dp_total;
    logic             dp_carry;
    logic             dp_ov;

    modport master (
        output start, op, a_in, b_in, use_acc, dp_total, dp_carry, dp_ov,
        input  busy, done, result, carry, ov, dp_a, dp_b, dp_s
    );

    modport slave (
        input  start, op, a_in, b_in, use_acc, dp_total, dp_carry, dp_ov,
        output busy, done, result, carry, ov, dp_a, dp_b, dp_s
    );
endinterface

// File: rtl/addsub_seq_ctrl.sv
// Sequencing controller for the shared add/subtract datapath: single-cycle add/sub,
// accumulate, clear, and multiply by repeated addition through the same datapath.
module addsub_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    addsub_seq_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_acc;
    logic             r_sticky;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_ov;

    state_t           w_stateNext;
    logic [1:0]       w_opNext;
    logic [WIDTH-1:0] w_opANext;
    logic [WIDTH-1:0] w_opBNext;
    logic [WIDTH-1:0] w_countNext;
    logic [WIDTH-1:0] w_accNext;
    logic             w_stickyNext;
    logic [WIDTH-1:0] w_resultNext;
    logic             w_carryNext;
    logic             w_ovNext;
    logic [WIDTH-1:0] w_dpA;
    logic [WIDTH-1:0] w_dpB;
    logic             w_dpS;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_op     <= '0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_count  <= '0;
            r_acc    <= '0;
            r_sticky <= 1'b0;
            r_result <= '0;
            r_carry  <= 1'b0;
            r_ov     <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_op     <= w_opNext;
            r_opA    <= w_opANext;
            r_opB    <= w_opBNext;
            r_count  <= w_countNext;
            r_acc    <= w_accNext;
            r_sticky <= w_stickyNext;
            r_result <= w_resultNext;
            r_carry  <= w_carryNext;
            r_ov     <= w_ovNext;
        end
    end

    always_comb begin
        w_stateNext  = r_state;
        w_opNext     = r_op;
        w_opANext    = r_opA;
        w_opBNext    = r_opB;
        w_countNext  = r_count;
        w_accNext    = r_acc;
        w_stickyNext = r_sticky;
        w_resultNext = r_result;
        w_carryNext  = r_carry;
        w_ovNext     = r_ov;
        w_dpA        = '0;
        w_dpB        = '0;
        w_dpS        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_opNext  = bus.op;
                    w_opANext = bus.use_acc ? r_result : bus.a_in;
                    w_opBNext = bus.b_in;
                    case (bus.op)
                        OP_ADD, OP_SUB: w_stateNext = S_EXEC;
                        OP_MUL: begin
                            w_accNext    = '0;
                            w_countNext  = bus.b_in;
                            w_stickyNext = 1'b0;
                            w_stateNext  = S_MUL;
                        end
                        OP_CLR: begin
                            w_resultNext = '0;
                            w_carryNext  = 1'b0;
                            w_ovNext     = 1'b0;
                            w_stateNext  = S_DONE;
                        end
                        default: w_stateNext = S_IDLE;
                    endcase
                end
            end
            S_EXEC: begin
                w_dpA        = r_opA;
                w_dpB        = r_opB;
                w_dpS        = r_op[0];
                w_resultNext = bus.dp_total;
                w_carryNext  = bus.dp_carry;
                w_ovNext     = bus.dp_ov;
                w_stateNext  = S_DONE;
            end
            S_MUL: begin
                // Multiplicand is re-added to the accumulator once per remaining count.
                w_dpA = r_acc;
                w_dpB = r_opA;
                if (r_count != '0) begin
                    w_accNext    = bus.dp_total;
                    w_stickyNext = r_sticky | bus.dp_carry;
                    w_countNext  = r_count - 1'b1;
                end else begin
                    w_resultNext = r_acc;
                    w_carryNext  = r_sticky;
                    w_ovNext     = 1'b0;
                    w_stateNext  = S_DONE;
                end
            end
            S_DONE: w_stateNext = S_IDLE;
            default: w_stateNext = S_IDLE;
        endcase
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;
    assign bus.carry  = r_carry;
    assign bus.ov     = r_ov;
    assign bus.dp_a   = w_dpA;
    assign bus.dp_b   = w_dpB;
    assign bus.dp_s   = w_dpS;
endmodule
